bcd_serial_addsub: RTL and testbench

- Parametrised N-digit packed-BCD adder/subtractor for the calculator datapath.
- Processes one BCD digit per clock, least-significant digit first, behind a valid/ready handshake.
- Flags add overflow, subtract underflow and non-BCD input digits.
- Sits between the switch/operand capture logic and the 7-segment display drivers; the display blanks the result when any flag is set.

---
 rtl/bcd_calc_pkg.sv | 18 +
 rtl/bcd_digit_addc.sv | 24 ++
 rtl/bcd_serial_addsub.sv | 176 +++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_calc_pkg.sv
// Shared definitions for the calculator's BCD datapath.
//   OP_ADD / OP_SUB : encoding of the op input.
//   state_t         : sequencing states of the serial add/subtract unit.
//   BCD_MAX_DIGIT   : largest legal BCD digit value.
package bcd_calc_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_addc.sv
// Single BCD digit adder with carry.
//   x, y : digit operands (y may be a nine's complement digit)
//   cin  : carry in
//   s    : corrected BCD sum digit
//   cout : decimal carry out
// Binary sum first, then +6 when the sum leaves the 0..9 range so the low
// nibble wraps back into BCD and the carry moves to the next digit.
module bcd_digit_addc
  import bcd_calc_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] bin_sum;

  assign bin_sum = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
  assign cout    = (bin_sum > {1'b0, BCD_MAX_DIGIT});
  assign s       = cout ? 4'(bin_sum + 5'd6) : bin_sum[3:0];

endmodule

// File: rtl/bcd_serial_addsub.sv
// Serial N-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake; a, b, op captured on in_valid & in_ready
//   op                  : 0 = a+b, 1 = a-b
//   a, b                : packed BCD operands, digit 0 in bits [3:0]
//   out_valid/out_ready : result handshake; result and flags held until taken
//   result              : packed BCD result (zero whenever a flag is set)
//   overflow            : sum exceeds 10^DIGITS-1
//   underflow           : subtract with a < b
//   bad_digit           : some operand nibble was above 9
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and the producer holds its data
// until the transfer. in_ready is high only in IDLE, out_valid only in DONE.
//
// Subtraction is a + (nine's complement of b) + 1, so the final carry is 1
// exactly when a >= b. The FSM state is kept in state_q for observation.
module bcd_serial_addsub
  import bcd_calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   result,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  bad_digit
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            op_q;
  logic [W-1:0]    a_q, b_q;
  logic            bad_in_q;    // captured operand check, reported at DONE
  logic [W-1:0]    result_q;
  logic            overflow_q, underflow_q, bad_digit_q;

  logic            accept;
  logic            in_bad;
  logic [3:0]      a_dig, b_dig, y_dig, s_dig;
  logic            cout;
  logic            last_digit;

  // Operand nibble legality, checked on the raw inputs at acceptance.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > BCD_MAX_DIGIT) || (b[4*i +: 4] > BCD_MAX_DIGIT)) begin
        in_bad = 1'b1;
      end
    end
  end

  // Current digit select; a mux on the counter keeps the per-cycle path to
  // one digit adder regardless of DIGITS.
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
  end

  assign y_dig      = (op_q == OP_SUB) ? (BCD_MAX_DIGIT - b_dig) : b_dig;
  assign last_digit = (cnt_q == LAST_DIGIT);

  bcd_digit_addc u_digit (
    .x    (a_dig),
    .y    (y_dig),
    .cin  (carry_q),
    .s    (s_dig),
    .cout (cout)
  );

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      bad_in_q    <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      bad_digit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q         <= a;
            b_q         <= b;
            op_q        <= op;
            carry_q     <= op;  // +1 of the ten's complement on subtract
            cnt_q       <= '0;
            bad_in_q    <= in_bad;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            bad_digit_q <= 1'b0;
          end
        end
        CALC: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) result_q[4*i +: 4] <= s_dig;
          end
          carry_q <= cout;
          if (last_digit) begin
            // Flag priority: bad digit, then overflow, then underflow.
            // The later full-width assignment overrides the digit write above.
            if (bad_in_q) begin
              bad_digit_q <= 1'b1;
              result_q    <= '0;
            end else if ((op_q == OP_ADD) && cout) begin
              overflow_q <= 1'b1;
              result_q   <= '0;
            end else if ((op_q == OP_SUB) && !cout) begin
              underflow_q <= 1'b1;
              result_q    <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;  // DONE holds everything until the consumer takes it
      endcase
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign bad_digit = bad_digit_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub with DIGITS = 1, 4 and 8 instances side by side.
// Expected results come from a decimal model and are queued at acceptance;
// monitors pop and compare on each output handshake.
module tb_bcd_serial_addsub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        op = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a_bus = '0;
  logic [31:0] b_bus = '0;
  logic        in_valid1 = 1'b0, in_valid4 = 1'b0, in_valid8 = 1'b0;
  logic        in_ready1, in_ready4, in_ready8;
  logic        out_valid1, out_valid4, out_valid8;
  logic [3:0]  result1;
  logic [15:0] result4;
  logic [31:0] result8;
  logic        ov1, ov4, ov8, un1, un4, un8, bd1, bd4, bd8;

  bcd_serial_addsub #(.DIGITS(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op), .a(a_bus[3:0]), .b(b_bus[3:0]), .out_valid(out_valid1),
    .out_ready(out_ready), .result(result1), .overflow(ov1),
    .underflow(un1), .bad_digit(bd1)
  );

  bcd_serial_addsub #(.DIGITS(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op), .a(a_bus[15:0]), .b(b_bus[15:0]), .out_valid(out_valid4),
    .out_ready(out_ready), .result(result4), .overflow(ov4),
    .underflow(un4), .bad_digit(bd4)
  );

  bcd_serial_addsub #(.DIGITS(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op), .a(a_bus), .b(b_bus), .out_valid(out_valid8),
    .out_ready(out_ready), .result(result8), .overflow(ov8),
    .underflow(un8), .bad_digit(bd8)
  );

  // {bad_digit, overflow, underflow, result zero-extended to 32 bits}
  logic [34:0] got1, got4, got8;
  assign got1 = {bd1, ov1, un1, 28'd0, result1};
  assign got4 = {bd4, ov4, un4, 16'd0, result4};
  assign got8 = {bd8, ov8, un8, result8};

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q1[$];
  logic [34:0] exp_q4[$];
  logic [34:0] exp_q8[$];
  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Decimal reference model.
  function automatic logic [34:0] model(input int d, input logic o,
                                        input logic [31:0] x, input logic [31:0] y);
    longint xv = 0, yv = 0, lim = 1, v = 0;
    logic bdf = 1'b0, ovf = 1'b0, unf = 1'b0;
    logic [31:0] r = '0;
    logic [3:0] nx, ny;
    for (int i = d - 1; i >= 0; i--) begin
      nx = x[4*i +: 4];
      ny = y[4*i +: 4];
      if (nx > 4'd9 || ny > 4'd9) bdf = 1'b1;
      xv = xv * 10 + longint'(nx);
      yv = yv * 10 + longint'(ny);
      lim = lim * 10;
    end
    if (!bdf) begin
      if (!o) begin
        v = xv + yv;
        if (v >= lim) ovf = 1'b1;
      end else begin
        if (xv < yv) unf = 1'b1;
        else v = xv - yv;
      end
    end
    if (!bdf && !ovf && !unf) begin
      for (int i = 0; i < d; i++) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return {bdf, ovf, unf, r};
  endfunction

  function automatic logic [31:0] rand_bcd(input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Monitors: compare on every output handshake.
  always @(negedge clk) begin
    if (out_valid1 && out_ready) begin
      check("d1_pending", 35'(exp_q1.size() > 0), 35'd1);
      if (exp_q1.size() > 0) check("d1_result", got1, exp_q1.pop_front());
    end
    if (out_valid4 && out_ready) begin
      check("d4_pending", 35'(exp_q4.size() > 0), 35'd1);
      if (exp_q4.size() > 0) check("d4_result", got4, exp_q4.pop_front());
    end
    if (out_valid8 && out_ready) begin
      check("d8_pending", 35'(exp_q8.size() > 0), 35'd1);
      if (exp_q8.size() > 0) check("d8_result", got8, exp_q8.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic rdy(input int sel);
    case (sel)
      1: return in_ready1;
      4: return in_ready4;
      default: return in_ready8;
    endcase
  endfunction

  // Drive one operation into instance sel; returns #1 after the accepting edge.
  task automatic issue(input int sel, input logic o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    @(negedge clk);
    while (!rdy(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("issue_timeout", 35'(n), 35'd0);
      return;
    end
    op = o;
    a_bus = x;
    b_bus = y;
    case (sel)
      1: in_valid1 = 1'b1;
      4: in_valid4 = 1'b1;
      default: in_valid8 = 1'b1;
    endcase
    @(posedge clk);
    case (sel)
      1: exp_q1.push_back(model(1, o, x, y));
      4: exp_q4.push_back(model(4, o, x, y));
      default: exp_q8.push_back(model(8, o, x, y));
    endcase
    #1;
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    // Scramble inputs: operands must already be captured.
    op = 1'($urandom_range(0, 1));
    a_bus = $urandom;
    b_bus = $urandom;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q1.size() + exp_q4.size() + exp_q8.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 35'(exp_q1.size() + exp_q4.size() + exp_q8.size()), 35'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [34:0] exp_bp;

    // Reset state.
    #1;
    check("rst_ready", 35'({in_ready1, in_ready4, in_ready8}), 35'b111);
    check("rst_valid", 35'({out_valid1, out_valid4, out_valid8}), 35'd0);
    check("rst_out4", got4, 35'd0);
    check("rst_out8", got8, 35'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Latency: out_valid DIGITS+1 cycles after the accepting cycle.
    issue(4, 1'b0, 32'h1234, 32'h5678);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid4 && n < 50);
    check("latency4", 35'(n), 35'd5);

    // Directed vectors, DIGITS=4.
    issue(4, 1'b0, 32'h9999, 32'h0001);
    issue(4, 1'b1, 32'h0500, 32'h0499);
    issue(4, 1'b1, 32'h0123, 32'h0123);
    issue(4, 1'b1, 32'h0499, 32'h0500);
    issue(4, 1'b0, 32'h12A4, 32'h0001);
    issue(4, 1'b1, 32'h0000, 32'h00F0);
    issue(4, 1'b0, 32'h4999, 32'h5000);
    // DIGITS=1.
    issue(1, 1'b0, 32'h4, 32'h5);
    issue(1, 1'b0, 32'h9, 32'h1);
    issue(1, 1'b1, 32'h5, 32'h3);
    issue(1, 1'b1, 32'h3, 32'h5);
    issue(1, 1'b1, 32'h7, 32'h7);
    issue(1, 1'b0, 32'hC, 32'h1);
    // DIGITS=8.
    issue(8, 1'b0, 32'h12345678, 32'h87654321);
    issue(8, 1'b0, 32'h99999999, 32'h00000001);
    issue(8, 1'b1, 32'h10000000, 32'h00000001);
    issue(8, 1'b1, 32'h00000001, 32'h10000000);
    issue(8, 1'b0, 32'h123F5678, 32'h00000000);
    wait_drain();

    // Random valid-BCD traffic on all widths.
    for (int k = 0; k < 8; k++) begin
      issue(1, 1'($urandom_range(0, 1)), rand_bcd(1), rand_bcd(1));
      issue(4, 1'($urandom_range(0, 1)), rand_bcd(4), rand_bcd(4));
      issue(8, 1'($urandom_range(0, 1)), rand_bcd(8), rand_bcd(8));
    end
    wait_drain();

    // Back-pressure: result held, no second accept while DONE.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(4, 1'b1, 32'h0500, 32'h0499);
    exp_bp = model(4, 1'b1, 32'h0500, 32'h0499);
    n = 0;
    while (!out_valid4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid4 = 1'b1;
    op = 1'b0;
    a_bus = 32'h1111;
    b_bus = 32'h2222;
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", got4, exp_bp);
      check("bp_valid", 35'(out_valid4), 35'd1);
      check("bp_in_ready", 35'(in_ready4), 35'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_at_hs", 35'(in_ready4), 35'd0);
    @(negedge clk);
    check("bp_ready_after", 35'(in_ready4), 35'd1);
    check("bp_valid_after", 35'(out_valid4), 35'd0);
    check("bp_queue", 35'(exp_q4.size()), 35'd0);
    repeat (8) @(negedge clk);
    check("bp_no_extra", 35'(out_valid4), 35'd0);

    // Asynchronous reset in the middle of CALC (counter at 2).
    issue(4, 1'b0, 32'h1234, 32'h5678);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 35'(in_ready4), 35'd1);
    check("mid_rst_valid", 35'(out_valid4), 35'd0);
    check("mid_rst_out", got4, 35'd0);
    exp_q4.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_quiet", 35'(out_valid4), 35'd0);
    issue(4, 1'b0, 32'h0001, 32'h0001);
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
